// File: rtl/win3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and its consumers.
// Holds the default geometry and the window tap index used by the
// multiplier array to pick taps in row-major order.
package win3x3_gen_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned IMG_W_DEF  = 32;
  localparam int unsigned IMG_H_DEF  = 32;
  localparam int unsigned CNT_W_DEF  = 6;
  localparam int unsigned NUM_TAPS   = 9;

  // Row-major tap position inside the 3x3 window (TL = oldest row/column).
  typedef enum logic [3:0] {
    TL = 4'd0,
    TM = 4'd1,
    TR = 4'd2,
    ML = 4'd3,
    MM = 4'd4,
    MR = 4'd5,
    BL = 4'd6,
    BM = 4'd7,
    BR = 4'd8
  } tap_idx_e;

endpackage

// File: rtl/win_line_buf.sv
// One image row of pixel storage, indexed by column.
// Read-before-write: rdata_c returns the entry at addr as it was before the
// write that happens on the same rising edge.
// Ports: clk, we (write enable), addr (column), wdata (new entry),
//        rdata_c (combinational read of the current entry).
module win_line_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  // Contents are never reset; they are masked by win_valid until refilled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/win3x3_gen.sv
// 3x3 sliding-window generator: turns a raster pixel stream into nine taps
// per output position ("valid" convolution, no border padding).
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   pix_in/pix_valid   input pixel stream, row-major raster order
//   pix_ready          combinational: block can take a pixel this cycle
//   win0..win8         registered taps, win0 = (r-2,c-2) ... win8 = (r,c)
//   win_valid          taps hold a complete window
//   win_last           final window of the frame
//   win_ready          downstream accepts the window
module win3x3_gen
  import win3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              win_valid,
  output logic              win_last,
  input  logic              win_ready
);

  localparam int unsigned LB_AW = $clog2(IMG_W);

  logic [CNT_W-1:0]  row;
  logic [CNT_W-1:0]  col;
  logic [DATA_W-1:0] win_q [NUM_TAPS];
  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;
  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              full_win;

  // A held window blocks intake so nothing downstream of it can change.
  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  assign col_last = (col == CNT_W'(IMG_W - 1));
  assign row_last = (row == CNT_W'(IMG_H - 1));
  assign full_win = (row >= CNT_W'(2)) && (col >= CNT_W'(2));

  // lb0 holds row r-1; lb1 holds row r-2 (fed from lb0's old entry).
  win_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (LB_AW)
  ) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[LB_AW-1:0]),
    .wdata   (pix_in),
    .rdata_c (lb0_rd)
  );

  win_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .AW     (LB_AW)
  ) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col[LB_AW-1:0]),
    .wdata   (lb0_rd),
    .rdata_c (lb1_rd)
  );

  // Raster counters, window shift register and output qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_q     <= '{default: '0};
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
      // Shift left one column; the new right column comes from the buffers.
      win_q[TL] <= win_q[TM];
      win_q[TM] <= win_q[TR];
      win_q[TR] <= lb1_rd;
      win_q[ML] <= win_q[MM];
      win_q[MM] <= win_q[MR];
      win_q[MR] <= lb0_rd;
      win_q[BL] <= win_q[BM];
      win_q[BM] <= win_q[BR];
      win_q[BR] <= pix_in;
      // Columns 0..1 and rows 0..1 leave stale taps, so they stay invalid.
      win_valid <= full_win;
      win_last  <= full_win && row_last && col_last;
    end else if (win_valid && win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

  assign win0 = win_q[TL];
  assign win1 = win_q[TM];
  assign win2 = win_q[TR];
  assign win3 = win_q[ML];
  assign win4 = win_q[MM];
  assign win5 = win_q[MR];
  assign win6 = win_q[BL];
  assign win7 = win_q[BM];
  assign win8 = win_q[BR];

endmodule

// File: tb/tb_win3x3_gen.sv
// Scoreboard bench for win3x3_gen on a 4x4 image. The driver records every
// accepted pixel into an image array and, for each position that completes a
// window, pushes the nine expected taps read straight from that array. The
// monitor pops and compares whenever a window transfers.
module tb_win3x3_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic          win_valid;
  logic          win_last;
  logic          win_ready;

  always #5 clk = ~clk;

  win3x3_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .win0      (win0),
    .win1      (win1),
    .win2      (win2),
    .win3      (win3),
    .win4      (win4),
    .win5      (win5),
    .win6      (win6),
    .win7      (win7),
    .win8      (win8),
    .win_valid (win_valid),
    .win_last  (win_last),
    .win_ready (win_ready)
  );

  typedef struct packed {
    logic                last;
    logic [8:0][DW-1:0]  taps;
  } exp_t;

  exp_t               q[$];
  int                 checks    = 0;
  int                 errors    = 0;
  int                 win_seen  = 0;
  int                 last_seen = 0;
  int                 stall_cmd = 0;
  bit                 rnd_ready = 1'b0;
  int                 img [H][W];
  logic [8:0][DW-1:0] dut_taps;

  assign dut_taps = {win8, win7, win6, win5, win4, win3, win2, win1, win0};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Downstream ready: a requested stall holds 3 cycles once a window is up.
  initial begin : ready_gen
    int stall_seen;
    int stall_left;
    stall_seen = 0;
    stall_left = 0;
    win_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_cmd != stall_seen) begin
        stall_seen = stall_cmd;
        stall_left = 3;
      end
      if (stall_left > 0 && win_valid === 1'b1) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  // Monitor: compares each transferring window against the scoreboard.
  initial begin : monitor
    logic [8:0][DW-1:0] held;
    logic               held_last;
    bit                 held_v;
    exp_t               e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) begin
        held_v = 1'b0;
      end else begin
        if (held_v)
          chk("stall_hold", 80'({win_valid, win_last, dut_taps}),
              80'({1'b1, held_last, held}));
        held_v = 1'b0;
        if (win_valid === 1'b1 && win_ready === 1'b0) begin
          chk("stall_pix_ready", 80'(pix_ready), 80'(1'b0));
          held      = dut_taps;
          held_last = win_last;
          held_v    = 1'b1;
        end
        if (win_valid === 1'b1 && win_ready === 1'b1) begin
          win_seen++;
          if (win_last === 1'b1) last_seen++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window: got taps %h expected none at %0t", dut_taps, $time);
          end else begin
            e = q.pop_front();
            chk("win_taps", 80'(dut_taps), 80'(e.taps));
            chk("win_last", 80'(win_last), 80'(e.last));
          end
        end
      end
    end
  end

  // Offer one pixel, wait (bounded) for acceptance, then update the model.
  task automatic send(input int r, input int c, input int val, input int gap_pct);
    int   n;
    exp_t e;
    while ($urandom_range(99) < 32'(gap_pct)) begin
      @(negedge clk);
      pix_valid = 1'b0;
    end
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = DW'(val);
    #1;
    n = 0;
    while (pix_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pix_ready !== 1'b1) begin
      $display("FAIL pix_ready_timeout: got %b expected 1 at %0t", pix_ready, $time);
      $fatal(1, "pixel never accepted");
    end
    img[r][c] = val;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.taps[3*i+j] = DW'(img[r-2+i][c-2+j]);
      e.last = (r == H - 1) && (c == W - 1);
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int base, input int npix, input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r * W + c < npix) send(r, c, base + r * W + c, gap_pct);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  initial begin : main
    int n;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_in    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_win_valid", 80'(win_valid), 80'(1'b0));
    chk("rst_win_last",  80'(win_last),  80'(1'b0));
    chk("rst_taps",      80'(dut_taps),  80'(0));
    chk("rst_pix_ready", 80'(pix_ready), 80'(1'b1));

    send_frame(0, 16, 0);                // continuous stream
    stall_cmd++;
    send_frame(0, 16, 0);                // 3-cycle stall on first window
    rnd_ready = 1'b1;
    send_frame(0, 16, 50);               // random bubbles and backpressure
    rnd_ready = 1'b0;
    send_frame(0, 16, 0);                // two frames back to back
    send_frame(100, 16, 0);

    send_frame(0, 10, 0);                // partial frame, then reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_win_valid", 80'(win_valid), 80'(1'b0));
    rst = 1'b0;
    send_frame(50, 16, 0);

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 80'(q.size()), 80'(0));
    chk("window_count",  80'(win_seen),  80'(24));
    chk("last_count",    80'(last_seen), 80'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/win3x3_gen.md
Name: win3x3_gen

Overview:
- Producer end of the 3x3 convolution datapath: turns a raster pixel stream into nine window taps per output position.
- Each window feeds nine multipliers, whose 21-bit signed products go to the 9-input adder stage.
- Two line buffers plus a 3x3 register window; valid/ready handshake on both sides; no padding ("valid" convolution only).

Parameters:
- DATA_W, 8, pixel width (unsigned).
- IMG_W, 32, image width in pixels (>=3).
- IMG_H, 32, image height in rows (>=3).
- CNT_W, 6, counter width; must satisfy 2^CNT_W >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  DATA_W  input pixel, raster order, row-major.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block can accept a pixel this cycle.
- win0..win8  out  DATA_W each  window taps, row-major: win0 = top-left (r-2,c-2), win8 = bottom-right (r,c).
- win_valid  out  1  taps hold a complete window.
- win_last  out  1  qualifies the final window of the frame.
- win_ready  in  1  downstream accepts the window.

Behaviour:
- Reset (synchronous, active-high):
  - row and col counters go to 0; win_valid and win_last go to 0.
  - win0..win8 go to 0.
  - Line-buffer contents are don't-care; they are never exposed while invalid.
- Handshake:
  - pix_ready = !win_valid || win_ready (combinational).
  - A pixel is accepted when pix_valid && pix_ready.
  - A window transfers when win_valid && win_ready.
  - win0..8, win_valid and win_last are held stable while win_valid && !win_ready.
- Line buffers: lb0 holds row r-1, lb1 holds row r-2; each is IMG_W entries deep, indexed by col.
- On each accepted pixel p at (row, col):
  - Write lb1[col] <= lb0[col] and lb0[col] <= p; read both old values in the same cycle.
  - Shift the window left by one column.
  - Load the new right column: win2 <= lb1[col], win5 <= lb0[col], win8 <= p.
  - win0 <= win1, win1 <= win2, win3 <= win4, win4 <= win5, win6 <= win7, win7 <= win8.
- win_valid:
  - Set on the cycle after accepting a pixel with row >= 2 && col >= 2.
  - On any other accept, win_valid <= 0, unless that cycle is a held stall; a held stall cannot occur on an accept, because pix_ready would be 0.
  - With no accept: a window transfer clears win_valid; otherwise it holds.
- Latency: one clk from pixel accept to the window appearing.
- Throughput: one window per clk under continuous valid/ready.
- Columns 0..1 of each row: window contents are stale across the row wrap; masked because win_valid = 0.
- win_last = win_valid for the pixel at (IMG_H-1, IMG_W-1).
- Counters:
  - col increments on accept and wraps IMG_W-1 -> 0, incrementing row.
  - row wraps IMG_H-1 -> 0, which starts the next frame.
  - Frames are back-to-back with no gap required.
- Windows per frame: (IMG_H-2)*(IMG_W-2).
- Backpressure: with win_ready = 0 and win_valid = 1, pix_ready = 0, and no counter, buffer or window state changes.
- Reset mid-frame: the partial frame is discarded and the next accepted pixel is treated as (0,0).
- pix_valid = 0 bubbles: no state change; window output is unaffected.
- Arithmetic: counters are unsigned CNT_W bits with explicit compare-and-wrap, never relying on power-of-two overflow.

Decomposition:
- Shared package: DATA_W, IMG_W and IMG_H defaults; a window tap index enum (TL=0 ... BR=8) shared with the multiplier array.
- One natural sub-module: win_line_buf.
  - Single-port-style read-before-write RAM of IMG_W x DATA_W.
  - One instance per row buffer; swappable for an SRAM macro later.
- Counters and the window register array stay in the top.

Test Plan (IMG_W=4, IMG_H=4, pixel value = 4*row+col, checked 1 clk after accept):
- Continuous stream, win_ready=1 -> exactly 4 windows.
  - First window, after pixel 10: 0,1,2,4,5,6,8,9,10.
  - Second window: 1,2,3,5,6,7,9,10,11.
  - Fourth window: 5,6,7,9,10,11,13,14,15 with win_last=1; win_last=0 on the other three.
- Stall win_ready=0 for 3 cycles while the first window is valid:
  - pix_ready=0 and taps held at 0..10.
  - Releasing win_ready yields the second window with no loss or duplication.
- Random pix_valid gaps (~50%) -> same 4 windows in the same order; win_valid never asserts for col<2 or row<2.
- Two frames back-to-back (second frame value = 100 + 4*row+col):
  - Frame 2 first window is 100,101,102,104,105,106,108,109,110.
  - Total windows = 8; win_last asserts twice.
- rst asserted after pixel 9 of frame 1, then a full frame with value = 50 + 4*row+col:
  - win_valid=0 during reset.
  - First window is 50,51,52,54,55,56,58,59,60.
- Reset state: one cycle after rst with pix_valid=0 -> win_valid=0, win_last=0, win0..8=0, pix_ready=1.
